// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer that owns every update of the 8-bit program counter.
// Optional fetch timeout (fault + halt) is enabled by defining PC_SEQUENCER_TIMEOUT_EN.
module pc_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             res,
  input  logic             run,
  input  logic             halt,
  input  logic [WIDTH-1:0] pc_q,
  input  logic             mem_ack,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_clr,
  output logic [WIDTH-1:0] pc_d,
  output logic             mem_req,
  output logic             ir_load,
  output logic             exec_start,
  output logic             wrap,
  output logic             fault,
  output logic             busy
);

  // state   | meaning
  // IDLE    | after reset, waiting for run
  // FETCH   | mem_req high, waiting for mem_ack
  // DECODE  | one-cycle instruction-register capture
  // EXEC    | execute stage running, waiting for exec_done
  // UPDATE  | one-cycle PC load (taken branch) or increment
  // HALTED  | parked at an instruction boundary
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED} state_t;

  state_t           state_q, state_d;
  logic             clr_q;
  logic             mem_req_q, mem_req_d;
  logic             ir_load_q, ir_load_d;
  logic             exec_start_q, exec_start_d;
  logic             pc_load_q, pc_load_d;
  logic             pc_inc_q, pc_inc_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

`ifdef PC_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef PC_SEQUENCER_TIMEOUT_EN
    tmr_d   = tmr_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE:   if (run && !halt) state_d = FETCH;
      FETCH: begin
        if (mem_ack) state_d = DECODE;
`ifdef PC_SEQUENCER_TIMEOUT_EN
        else if (tmr_q == '0) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else tmr_d = tmr_q - TW'(1);
`endif
      end
      DECODE: state_d = EXEC;
      EXEC:   if (exec_done) state_d = UPDATE;
      UPDATE: state_d = (halt || !run) ? HALTED : FETCH;
      HALTED: if (run && !halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
`ifdef PC_SEQUENCER_TIMEOUT_EN
    // Down-counter reloads on every FETCH entry; terminal count is zero.
    if (state_d == FETCH && state_q != FETCH) tmr_d = TW'(TIMEOUT - 1);
`endif

    // Outputs are decoded from the next state so they come straight off flops.
    mem_req_d    = (state_d == FETCH);
    ir_load_d    = (state_d == DECODE);
    exec_start_d = (state_d == EXEC) && (state_q != EXEC);
    pc_load_d    = (state_q == EXEC) && exec_done && branch_taken;
    pc_inc_d     = (state_q == EXEC) && exec_done && !branch_taken;
    tgt_d        = pc_load_d ? branch_target : '0;
    busy_d       = (state_d != IDLE) && (state_d != HALTED);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= IDLE;
      clr_q        <= 1'b1;
      mem_req_q    <= 1'b0;
      ir_load_q    <= 1'b0;
      exec_start_q <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
      tgt_q        <= '0;
`ifdef PC_SEQUENCER_TIMEOUT_EN
      tmr_q        <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clr_q        <= 1'b0;
      mem_req_q    <= mem_req_d;
      ir_load_q    <= ir_load_d;
      exec_start_q <= exec_start_d;
      pc_load_q    <= pc_load_d;
      pc_inc_q     <= pc_inc_d;
      busy_q       <= busy_d;
      tgt_q        <= tgt_d;
`ifdef PC_SEQUENCER_TIMEOUT_EN
      tmr_q        <= tmr_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign pc_clr     = clr_q;
  assign mem_req    = mem_req_q;
  assign ir_load    = ir_load_q;
  assign exec_start = exec_start_q;
  assign pc_load    = pc_load_q;
  assign pc_inc     = pc_inc_q;
  assign pc_d       = tgt_q;
  assign busy       = busy_q;
  assign wrap       = pc_inc_q & (&pc_q);

`ifdef PC_SEQUENCER_TIMEOUT_EN
  assign fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: phase-level reference model, per-cycle compare,
// directed literal checks, then randomized traffic with a mid-run reset.
module tb_pc_sequencer;
  localparam int TIMEOUT = 15;

  logic       clk, res, run, halt, mem_ack, exec_done, branch_taken;
  logic [7:0] pc_q, branch_target, pc_d;
  logic       pc_load, pc_inc, pc_clr, mem_req, ir_load, exec_start, wrap, fault, busy;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .res(res), .run(run), .halt(halt), .pc_q(pc_q),
    .mem_ack(mem_ack), .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_clr(pc_clr), .pc_d(pc_d), .mem_req(mem_req), .ir_load(ir_load),
    .exec_start(exec_start), .wrap(wrap), .fault(fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register the sequencer controls.
  initial pc_q = 8'h00;
  always @(posedge clk) begin
    if (pc_clr)       pc_q <= 8'h00;
    else if (pc_load) pc_q <= pc_d;
    else if (pc_inc)  pc_q <= pc_q + 8'h01;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase of the instruction the block is in.
  localparam int M_IDLE = 0, M_FETCH = 1, M_DECODE = 2, M_EXEC = 3, M_UPDATE = 4, M_HALTED = 5;
  int         m_ph;
  bit         m_clr, m_first, m_taken, m_fault;
  int         m_wait;
  logic [7:0] m_target, m_pc;

  always @(posedge clk or negedge res) begin
    if (!res) begin
      m_ph = M_IDLE; m_clr = 1; m_first = 0; m_taken = 0; m_fault = 0;
      m_wait = 0; m_target = 8'h00; m_pc = 8'h00;
    end else begin
      m_clr = 0;
      case (m_ph)
        M_IDLE: if (run && !halt) begin m_ph = M_FETCH; m_wait = 0; end
        M_FETCH: begin
          if (mem_ack) m_ph = M_DECODE;
          else begin
            m_wait++;
`ifdef PC_SEQUENCER_TIMEOUT_EN
            if (m_wait == TIMEOUT) begin m_ph = M_HALTED; m_fault = 1; end
`endif
          end
        end
        M_DECODE: begin m_ph = M_EXEC; m_first = 1; end
        M_EXEC: begin
          m_first = 0;
          if (exec_done) begin
            m_taken = branch_taken; m_target = branch_target; m_ph = M_UPDATE;
          end
        end
        M_UPDATE: begin
          m_pc = m_taken ? m_target : m_pc + 8'h01;
          if (halt || !run) m_ph = M_HALTED;
          else begin m_ph = M_FETCH; m_wait = 0; end
        end
        M_HALTED: if (run && !halt) begin m_ph = M_FETCH; m_wait = 0; end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic       e_req, e_ir, e_es, e_ld, e_inc, e_clr, e_wrap, e_busy, e_fault;
    logic [7:0] e_pcd;
    if (!res) begin
      e_req = 0; e_ir = 0; e_es = 0; e_ld = 0; e_inc = 0; e_clr = 1;
      e_wrap = 0; e_busy = 0; e_fault = 0; e_pcd = 8'h00;
    end else begin
      e_req   = (m_ph == M_FETCH);
      e_ir    = (m_ph == M_DECODE);
      e_es    = (m_ph == M_EXEC) && m_first;
      e_ld    = (m_ph == M_UPDATE) && m_taken;
      e_inc   = (m_ph == M_UPDATE) && !m_taken;
      e_pcd   = e_ld ? m_target : 8'h00;
      e_wrap  = e_inc && (m_pc == 8'hFF);
      e_busy  = (m_ph != M_IDLE) && (m_ph != M_HALTED);
      e_clr   = m_clr;
      e_fault = m_fault;
      if (m_ph == M_FETCH && m_wait == 0) check("fetch_addr", pc_q, m_pc);
    end
    check("mem_req", mem_req, e_req);
    check("ir_load", ir_load, e_ir);
    check("exec_start", exec_start, e_es);
    check("pc_load", pc_load, e_ld);
    check("pc_inc", pc_inc, e_inc);
    check("pc_d", pc_d, e_pcd);
    check("wrap", wrap, e_wrap);
    check("busy", busy, e_busy);
    check("pc_clr", pc_clr, e_clr);
    check("fault", fault, e_fault);
  end

  task automatic wait_update(input string name);
    int n = 0;
    while (!(pc_load || pc_inc) && n < 40) begin @(negedge clk); n++; end
    check({name, "_reached"}, n < 40, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    res = 0; run = 0; halt = 0; mem_ack = 0; exec_done = 0;
    branch_taken = 0; branch_target = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pc_clr", pc_clr, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);

    // Free-running: every instruction takes four cycles.
    run = 1; mem_ack = 1; exec_done = 1;
    @(posedge clk); #1 res = 1;
    @(negedge clk);
    check("clr_after_release", pc_clr, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("seq_pc_inc", pc_inc, (k % 4) == 3);
      if (k % 4 == 0) begin
        check("seq_pc_q", pc_q, k / 4);
        check("seq_mem_req", mem_req, 1);
      end
    end

    // Taken branch from 0x05 to 0xA0.
    n = 0;
    while (!(mem_req && pc_q == 8'h05) && n < 40) begin @(negedge clk); n++; end
    check("reach_pc5", n < 40, 1);
    branch_taken = 1; branch_target = 8'hA0;
    wait_update("br_a0");
    check("br_pc_load", pc_load, 1);
    check("br_pc_d", pc_d, 8'hA0);
    check("br_pc_inc", pc_inc, 0);
    branch_target = 8'hFF;
    @(negedge clk);
    check("br_next_fetch", pc_q, 8'hA0);
    wait_update("br_ff");
    check("br_ff_pc_d", pc_d, 8'hFF);
    branch_taken = 0;
    @(negedge clk);
    check("ff_fetch", pc_q, 8'hFF);
    wait_update("wrap");
    check("wrap_pc_inc", pc_inc, 1);
    check("wrap_pulse", wrap, 1);

    // mem_ack delayed three cycles, then a long EXEC with halt raised inside it.
    mem_ack = 0; exec_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("wrap_next_fetch", pc_q, 8'h00);
      check("dly_mem_req", mem_req, i < 4);
      check("dly_ir_load", ir_load, i == 4);
      if (i == 3) mem_ack = 1;
      if (i == 5) begin check("dly_exec_start", exec_start, 1); halt = 1; end
    end
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("halt_busy_exec", busy, 1);
      check("halt_no_inc", pc_inc, 0);
      if (j == 5) exec_done = 1;
    end
    @(negedge clk);
    check("halt_update_inc", pc_inc, 1);
    repeat (3) begin
      @(negedge clk);
      check("halted_busy", busy, 0);
      check("halted_mem_req", mem_req, 0);
      check("halted_pc", pc_q, 8'h01);
    end
    halt = 0;
    @(negedge clk);
    check("resume_mem_req", mem_req, 1);
    check("resume_pc", pc_q, 8'h01);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      run          = ($urandom_range(0, 19) != 0);
      halt         = ($urandom_range(0, 14) == 0);
      mem_ack      = $urandom_range(0, 1);
      exec_done    = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (c == 1500) begin
        #2 res = 0;
        #1;
        check("async_abort_mem_req", mem_req, 0);
        check("async_abort_pc_clr", pc_clr, 1);
        @(posedge clk); @(posedge clk); #1 res = 1;
      end
    end

`ifdef PC_SEQUENCER_TIMEOUT_EN
    @(negedge clk);
    #2 res = 0;
    run = 1; halt = 0; mem_ack = 0;
    @(posedge clk); #1 res = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) n++;
      else if (n > 0) break;
    end
    check("to_req_cycles", n, TIMEOUT);
    check("to_fault", fault, 1);
    check("to_mem_req", mem_req, 0);
    check("to_busy", busy, 0);
    run = 0;
    repeat (5) @(negedge clk);
    check("to_fault_sticky", fault, 1);
    #2 res = 0;
    #1 check("to_fault_cleared", fault, 0);
    @(posedge clk); #1 res = 1;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
